// File: rtl/dcache_req_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_req_arbiter_pkg: shared types and constants for the dcache arbiter|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package dcache_req_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } t_dcarb_state;

  typedef enum logic [1:0] {
    SOP_BYTE = 2'd0,
    SOP_HALF = 2'd1,
    SOP_WORD = 2'd2
  } t_sop;

  typedef enum logic [2:0] {
    LDOP_B  = 3'd0,
    LDOP_BU = 3'd1,
    LDOP_H  = 3'd2,
    LDOP_HU = 3'd3,
    LDOP_W  = 3'd4
  } t_ldop;

  localparam logic [31:0] DCARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dcache_req_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_req_arbiter_if: requester-side and dcache-side arbiter bundle     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface dcache_req_arbiter_if
  import dcache_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
) ();

  logic [NUM_REQ-1:0]                i_req;
  logic [NUM_REQ-1:0]                i_we;
  logic [NUM_REQ-1:0][ADDR_SIZE-1:0] i_addr;
  logic [NUM_REQ-1:0][DATA_SIZE-1:0] i_wdata;
  t_sop  [NUM_REQ-1:0]               i_sop;
  t_ldop [NUM_REQ-1:0]               i_ldop;
  logic [NUM_REQ-1:0]                o_ack;
  logic [NUM_REQ-1:0]                o_rvalid;
  logic [DATA_SIZE-1:0]              o_rdata;
  logic                              o_busy;

  logic                              o_c_req;
  logic                              o_c_we;
  logic [ADDR_SIZE-1:0]              o_c_addr;
  logic [DATA_SIZE-1:0]              o_c_wdata;
  t_sop                              o_c_sop;
  t_ldop                             o_c_ldop;
  logic                              i_c_ready;
  logic                              i_c_valid;
  logic [DATA_SIZE-1:0]              i_c_data;
  logic                              o_timeout;

  modport slave (
    input  i_req, i_we, i_addr, i_wdata, i_sop, i_ldop,
    input  i_c_ready, i_c_valid, i_c_data,
    output o_ack, o_rvalid, o_rdata, o_busy,
    output o_c_req, o_c_we, o_c_addr, o_c_wdata, o_c_sop, o_c_ldop,
    output o_timeout
  );

  modport master (
    output i_req, i_we, i_addr, i_wdata, i_sop, i_ldop,
    output i_c_ready, i_c_valid, i_c_data,
    input  o_ack, o_rvalid, o_rdata, o_busy,
    input  o_c_req, o_c_we, o_c_addr, o_c_wdata, o_c_sop, o_c_ldop,
    input  o_timeout
  );

endinterface
`default_nettype wire

// File: rtl/dcache_req_arbiter_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter: picks the first asserted request at/after the pointer        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int unsigned w_cand;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_cand  = 0;
    for (int k = 0; k < N; k++) begin
      // Candidate index wraps without a modulo so non-power-of-two N stays cheap.
      w_cand = 32'(i_ptr) + 32'(k);
      if (w_cand >= 32'(N)) begin
        w_cand = w_cand - 32'(N);
      end
      if (!o_valid && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = IW'(w_cand);
        o_valid         = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/dcache_req_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dcache_req_arbiter: round-robin sharing of one dcache port, single       |
// | outstanding transaction. Optional watchdog: define DCARB_TIMEOUT_EN.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dcache_req_arbiter
  import dcache_req_arbiter_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_SIZE      = 32,
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire logic            i_aclk,
  input  wire logic            i_areset_n,
  dcache_req_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dcache_req_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  t_dcarb_state         state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        owner_q, owner_d;
  logic                 c_req_q, c_req_d;
  logic                 c_we_q, c_we_d;
  logic [ADDR_SIZE-1:0] c_addr_q, c_addr_d;
  logic [DATA_SIZE-1:0] c_wdata_q, c_wdata_d;
  t_sop                 c_sop_q, c_sop_d;
  t_ldop                c_ldop_q, c_ldop_d;

  logic [NUM_REQ-1:0]   w_grant;
  logic [IW-1:0]        w_idx;
  logic                 w_valid;
  logic [NUM_REQ-1:0]   w_ack;
  logic [NUM_REQ-1:0]   w_rvalid;
  logic [NUM_REQ-1:0]   w_owner_oh;
  logic [DATA_SIZE-1:0] w_rdata;
  logic                 w_expire;

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .i_req   (bus.i_req),
    .i_ptr   (ptr_q),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_owner_oh = NUM_REQ'(1) << owner_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    c_req_d   = c_req_q;
    c_we_d    = c_we_q;
    c_addr_d  = c_addr_q;
    c_wdata_d = c_wdata_q;
    c_sop_d   = c_sop_q;
    c_ldop_d  = c_ldop_q;
    w_ack     = '0;
    w_rvalid  = '0;
    w_rdata   = '0;

    case (state_q)
      IDLE: begin
        // Gating by the reset pin keeps o_ack quiet while reset is held.
        if (i_areset_n && w_valid) begin
          w_ack     = w_grant;
          owner_d   = w_idx;
          ptr_d     = IW'(wrap_inc(32'(w_idx), 32'(NUM_REQ)));
          c_req_d   = 1'b1;
          c_we_d    = bus.i_we[w_idx];
          c_addr_d  = bus.i_addr[w_idx];
          c_wdata_d = bus.i_wdata[w_idx];
          c_sop_d   = bus.i_sop[w_idx];
          c_ldop_d  = bus.i_ldop[w_idx];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (w_expire) begin
          w_rvalid = w_owner_oh;
          w_rdata  = DATA_SIZE'(DCARB_TIMEOUT_DATA);
          c_req_d  = 1'b0;
          state_d  = IDLE;
        end else if (bus.i_c_ready) begin
          c_req_d  = 1'b0;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (bus.i_c_valid) begin
          w_rvalid = w_owner_oh;
          w_rdata  = c_we_q ? '0 : bus.i_c_data;
          state_d  = IDLE;
        end else if (w_expire) begin
          w_rvalid = w_owner_oh;
          w_rdata  = DATA_SIZE'(DCARB_TIMEOUT_DATA);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      owner_q   <= '0;
      c_req_q   <= 1'b0;
      c_we_q    <= 1'b0;
      c_addr_q  <= '0;
      c_wdata_q <= '0;
      c_sop_q   <= SOP_BYTE;
      c_ldop_q  <= LDOP_B;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      c_req_q   <= c_req_d;
      c_we_q    <= c_we_d;
      c_addr_q  <= c_addr_d;
      c_wdata_q <= c_wdata_d;
      c_sop_q   <= c_sop_d;
      c_ldop_q  <= c_ldop_d;
    end
  end

`ifdef DCARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Counter sits at zero in IDLE, so it starts from zero on entry to ISSUE.
  assign w_expire = (state_q != IDLE) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d     = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    timeout_d = timeout_q;
    if (w_expire && !(state_q == WAIT && bus.i_c_valid)) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  assign w_expire      = 1'b0;
  assign bus.o_timeout = 1'b0;
`endif

  assign bus.o_ack     = w_ack;
  assign bus.o_rvalid  = w_rvalid;
  assign bus.o_rdata   = w_rdata;
  assign bus.o_busy    = (state_q != IDLE);
  assign bus.o_c_req   = c_req_q;
  assign bus.o_c_we    = c_we_q;
  assign bus.o_c_addr  = c_addr_q;
  assign bus.o_c_wdata = c_wdata_q;
  assign bus.o_c_sop   = c_sop_q;
  assign bus.o_c_ldop  = c_ldop_q;

endmodule
`default_nettype wire
